// File: rtl/seq_subtractor.sv
// -----------------------------------------------------------------------------
// seq_subtractor
//   Multi-cycle wide-operand subtractor: diff = dd - aa (mod 2^NUM_BITS).
//   One CHUNK_BITS slice is subtracted per clock. The borrow between slices is
//   held in a register, so no carry path runs across the full operand width.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | in_ready high, waiting for the operand handshake
//   BUSY  | subtracting chunk cnt_q, least significant chunk first
//   DONE  | out_valid high, result held until out_ready
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands present on dd/aa
//   in_ready   block can accept operands (state == IDLE)
//   dd         minuend, NUM_BITS wide
//   aa         subtrahend, NUM_BITS wide
//   out_valid  result available (state == DONE)
//   out_ready  consumer accepts the result
//   diff       dd - aa modulo 2^NUM_BITS
//   borrow     final borrow out, 1 iff aa > dd (unsigned)
// -----------------------------------------------------------------------------
module seq_subtractor #(
    parameter int NUM_BITS   = 512,
    parameter int CHUNK_BITS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] dd,
    input  logic [NUM_BITS-1:0] aa,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] diff,
    output logic                borrow
);

    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                borrow_int_q, borrow_int_d;
    logic [NUM_BITS-1:0] dd_q, dd_d;
    logic [NUM_BITS-1:0] aa_q, aa_d;
    logic [NUM_BITS-1:0] diff_q, diff_d;
    logic                borrow_q, borrow_d;

    logic [CHUNK_BITS-1:0] dd_chunk;
    logic [CHUNK_BITS-1:0] aa_chunk;
    logic [CHUNK_BITS:0]   chunk_sub;
    logic                  last_chunk;

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)   state_d = S_BUSY;
            S_BUSY:  if (last_chunk) state_d = S_DONE;
            S_DONE:  if (out_ready)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode registered state only.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // ----------------------------------------------------------- datapath ---
    assign last_chunk = (cnt_q == LAST_CHUNK);

    // The extra top bit of the (CHUNK_BITS+1)-bit subtract is the borrow out.
    always_comb begin
        dd_chunk  = dd_q[cnt_q * CHUNK_BITS +: CHUNK_BITS];
        aa_chunk  = aa_q[cnt_q * CHUNK_BITS +: CHUNK_BITS];
        chunk_sub = {1'b0, dd_chunk} - {1'b0, aa_chunk}
                    - {{CHUNK_BITS{1'b0}}, borrow_int_q};
    end

    always_comb begin
        cnt_d        = cnt_q;
        borrow_int_d = borrow_int_q;
        dd_d         = dd_q;
        aa_d         = aa_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        case (state_q)
            S_IDLE: begin
                // diff/borrow keep the previous result until overwritten.
                if (in_valid) begin
                    dd_d         = dd;
                    aa_d         = aa;
                    cnt_d        = '0;
                    borrow_int_d = 1'b0;
                end
            end
            S_BUSY: begin
                diff_d[cnt_q * CHUNK_BITS +: CHUNK_BITS] = chunk_sub[CHUNK_BITS-1:0];
                borrow_int_d = chunk_sub[CHUNK_BITS];
                if (last_chunk) begin
                    borrow_d = chunk_sub[CHUNK_BITS];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            borrow_int_q <= 1'b0;
            dd_q         <= '0;
            aa_q         <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            borrow_int_q <= borrow_int_d;
            dd_q         <= dd_d;
            aa_q         <= aa_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
